// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands are captured on the accepting edge. Bits are consumed from bit 0 of
// the operand shift registers, and result bits are shifted in from the top.
// busy, done, diff and borrow_out are all registered.

module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Bit counter width. It must be able to hold the values 0..WIDTH-1 and is
    // never narrower than one bit.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_s;
    logic [WIDTH-1:0] res_sh_r, res_sh_s;
    logic             br_r, br_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             borrow_out_r, borrow_out_s;

    // Full-subtractor cell on the current LSBs.
    logic             d_s;
    logic             br_nx_s;

    assign d_s     = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
    assign br_nx_s = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & br_r);

    // Next-state, datapath and output decode; every target holds by default.
    always_comb begin
        state_s      = state_r;
        a_sh_s       = a_sh_r;
        b_sh_s       = b_sh_r;
        res_sh_s     = res_sh_r;
        br_s         = br_r;
        cnt_s        = cnt_r;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        diff_s       = diff_r;
        borrow_out_s = borrow_out_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    a_sh_s   = a;
                    b_sh_s   = b;
                    br_s     = borrow_in;
                    res_sh_s = {WIDTH{1'b0}};
                    cnt_s    = {CW{1'b0}};
                    state_s  = RUN;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                a_sh_s   = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_s   = {1'b0, b_sh_r[WIDTH-1:1]};
                res_sh_s = {d_s, res_sh_r[WIDTH-1:1]};
                br_s     = br_nx_s;
                if (cnt_r == CW'(WIDTH - 1)) begin
                    // The last bit is processed on this edge, so the result is
                    // published directly from the cell outputs.
                    diff_s       = {d_s, res_sh_r[WIDTH-1:1]};
                    borrow_out_s = br_nx_s;
                    cnt_s        = {CW{1'b0}};
                    state_s      = DONE;
                    done_s       = 1'b1;
                end else begin
                    cnt_s        = cnt_r + CW'(1);
                    busy_s       = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_sh_r       <= {WIDTH{1'b0}};
            b_sh_r       <= {WIDTH{1'b0}};
            res_sh_r     <= {WIDTH{1'b0}};
            br_r         <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            a_sh_r       <= a_sh_s;
            b_sh_r       <= b_sh_s;
            res_sh_r     <= res_sh_s;
            br_r         <= br_s;
            cnt_r        <= cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            diff_r       <= diff_s;
            borrow_out_r <= borrow_out_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit (WIDTH=4).
// Inputs are driven on the falling edge and outputs are sampled there.
// Expected results are queued at launch and popped when done is seen.

module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic       borrow_in;
    logic       busy, done;
    logic [3:0] diff;
    logic       borrow_out;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .borrow_in(borrow_in), .busy(busy), .done(done),
        .diff(diff), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference ripple-carry adder: returns {carry_out, sum}.
    function automatic logic [4:0] ripple_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] s;
        logic       cy;
        cy = c;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (x[i] & cy) | (y[i] & cy);
        end
        return {cy, s};
    endfunction

    // Drives a one-cycle start pulse and queues the expected result.
    // The task is entered on a falling edge and returns on the falling edge after E0.
    task automatic launch(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        exp_t       e;
        logic [4:0] r;
        r     = {1'b0, av} - {1'b0, bv} - {4'b0000, bi};
        e.a   = av;
        e.b   = bv;
        e.bin = bi;
        e.d   = r[3:0];
        e.bo  = r[4];
        sb.push_back(e);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits on falling edges for done, up to a bounded number of cycles.
    task automatic wait_done(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic quiet;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            borrow_in = 1'($urandom); start = 1'($urandom);
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (diff !== 4'h0) begin n_fail++; $display("FAIL reset_diff got %h want 0", diff); end
        n_checks++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
        start = 1'b0;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL idle_quiet got activity want none"); end
    endtask

    task automatic test_basic;
        exp_t e;
        logic ok;
        launch(4'd9, 4'd3, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_busy_window got bad busy/done want busy=1 for 4 cycles"); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b want 1/0", done, busy); end
        e = sb.pop_front();
        n_checks++; if (diff !== e.d) begin n_fail++; $display("FAIL basic_diff got %h want %h", diff, e.d); end
        n_checks++; if (borrow_out !== e.bo) begin n_fail++; $display("FAIL basic_borrow got %b want %b", borrow_out, e.bo); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_checks++; if (diff !== 4'd6) begin n_fail++; $display("FAIL basic_diff_hold got %h want 6", diff); end
    endtask

    task automatic test_borrow;
        logic [8:0] cases [3];
        exp_t       e;
        logic       got;
        cases[0] = {4'd3, 4'd9, 1'b0};
        cases[1] = {4'd0, 4'd0, 1'b1};
        cases[2] = {4'd15, 4'd15, 1'b0};
        for (int i = 0; i < 3; i++) begin
            launch(cases[i][8:5], cases[i][4:1], cases[i][0]);
            wait_done(got);
            n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL borrow_timeout case %0d got no done want done", i); end
            e = sb.pop_front();
            n_checks++; if (diff !== e.d) begin n_fail++; $display("FAIL borrow_diff case %0d got %h want %h", i, diff, e.d); end
            n_checks++; if (borrow_out !== e.bo) begin n_fail++; $display("FAIL borrow_bo case %0d got %b want %b", i, borrow_out, e.bo); end
            @(negedge clk);
        end
    endtask

    task automatic test_handshake;
        exp_t e;
        logic quiet;
        logic got;
        int   dt[$];
        launch(4'd9, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; a = 4'($urandom); b = 4'($urandom);
            if (i == 0) begin a = 4'd1; b = 4'd1; end
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hs_done got %b want 1", done); end
        n_checks++; if (diff !== e.d || borrow_out !== e.bo) begin n_fail++; $display("FAIL hs_result got %h/%b want %h/%b", diff, borrow_out, e.d, e.bo); end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL hs_dropped got extra activity want none"); end
        // start held high: acceptances on E0, E6, E12, E18
        for (int k = 0; k < 4; k++) begin
            e.a = 4'd5; e.b = 4'd2; e.bin = 1'b0; e.d = 4'd3; e.bo = 1'b0;
            sb.push_back(e);
        end
        a = 4'd5; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dt.push_back(cyc);
                e = sb.pop_front();
                n_checks++; if (diff !== e.d || borrow_out !== e.bo) begin n_fail++; $display("FAIL held_result got %h/%b want %h/%b", diff, borrow_out, e.d, e.bo); end
            end
        end
        start = 1'b0;
        n_checks++; if (dt.size() != 3) begin n_fail++; $display("FAIL held_count got %0d want 3", dt.size()); end
        if (dt.size() == 3) begin
            n_checks++; if (dt[0] != 5 || dt[1] - dt[0] != 6 || dt[2] - dt[1] != 6) begin n_fail++; $display("FAIL held_spacing got %0d,%0d,%0d want 5,11,17", dt[0], dt[1], dt[2]); end
        end
        wait_done(got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL held_drain got no done want done"); end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        exp_t e;
        logic quiet;
        logic got;
        launch(4'd12, 4'd5, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got %b/%b want 0/0", busy, done); end
        n_checks++; if (diff !== 4'h0 || borrow_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data got %h/%b want 0/0", diff, borrow_out); end
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) quiet = 1'b0;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_no_done got done pulse want none"); end
        launch(4'd12, 4'd5, 1'b0);
        wait_done(got);
        e = sb.pop_front();
        n_checks++; if (got !== 1'b1 || diff !== e.d || borrow_out !== e.bo) begin n_fail++; $display("FAIL mid_rerun got %h/%b want %h/%b", diff, borrow_out, e.d, e.bo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        logic       got;
        logic [4:0] sum;
        for (int i = 0; i < 512; i++) begin
            launch(i[8:5], i[4:1], i[0]);
            wait_done(got);
            if (got !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL sweep_timeout a=%0d b=%0d bin=%0d got no done want done", i[8:5], i[4:1], i[0]);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "sweep stalled");
            end
            e = sb.pop_front();
            n_checks++; if (diff !== e.d) begin n_fail++; $display("FAIL sweep_diff a=%0d b=%0d bin=%0d got %h want %h", e.a, e.b, e.bin, diff, e.d); end
            n_checks++; if (borrow_out !== e.bo) begin n_fail++; $display("FAIL sweep_borrow a=%0d b=%0d bin=%0d got %b want %b", e.a, e.b, e.bin, borrow_out, e.bo); end
            sum = ripple_add(diff, e.b, e.bin);
            n_checks++; if (sum !== {borrow_out, e.a}) begin n_fail++; $display("FAIL sweep_adder a=%0d b=%0d bin=%0d got %h want %h", e.a, e.b, e.bin, sum, {borrow_out, e.a}); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; borrow_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_borrow();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
